// File: rtl/riscv_mem_wb_stage_if.sv
// MEM->WB stage bundle: M-stage inputs, W-stage hazard controls and W-stage outputs.
// The master side drives M/control signals; the slave side (the stage) drives W outputs.
`ifndef XLEN
`define XLEN 32
`endif

interface riscv_mem_wb_stage_if #(
  parameter int XLEN  = `XLEN,
  parameter int RD_W  = 5,
  parameter int CNT_W = 64
);
  logic [XLEN-1:0]  i_read_data_m;
  logic [XLEN-1:0]  i_alu_result_m;
  logic [XLEN-1:0]  i_pc_plus4_m;
  logic [RD_W-1:0]  i_rd_m;
  logic             i_reg_write_m;
  logic [1:0]       i_result_src_m;
  logic [2:0]       i_funct3_m;
  logic             i_valid_m;
  logic             i_stall_w;
  logic             i_flush_w;
  logic [XLEN-1:0]  o_result_w;
  logic [RD_W-1:0]  o_rd_w;
  logic             o_reg_write_w;
  logic             o_valid_w;
  logic [CNT_W-1:0] o_instret;
  logic             o_misalign_w;

  modport master (
    output i_read_data_m, i_alu_result_m, i_pc_plus4_m, i_rd_m, i_reg_write_m,
           i_result_src_m, i_funct3_m, i_valid_m, i_stall_w, i_flush_w,
    input  o_result_w, o_rd_w, o_reg_write_w, o_valid_w, o_instret, o_misalign_w
  );

  modport slave (
    input  i_read_data_m, i_alu_result_m, i_pc_plus4_m, i_rd_m, i_reg_write_m,
           i_result_src_m, i_funct3_m, i_valid_m, i_stall_w, i_flush_w,
    output o_result_w, o_rd_w, o_reg_write_w, o_valid_w, o_instret, o_misalign_w
  );
endinterface

// File: rtl/riscv_mem_wb_stage.sv
// RV32I MEM->WB stage: load extraction, writeback mux, W registers and retired-instruction counter.
// Optional macro RISCV_LOAD_MISALIGN_EN flags misaligned LH/LHU/LW and suppresses their register write.
`ifndef XLEN
`define XLEN 32
`endif

module riscv_mem_wb_stage #(
  parameter int XLEN  = `XLEN,
  parameter int RD_W  = 5,
  parameter int CNT_W = 64
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  riscv_mem_wb_stage_if.slave   bus
);

  // Sub-word selection uses only addr[1:0]; the memory word is always word-aligned.
  function automatic logic [XLEN-1:0] extract_load(input logic [XLEN-1:0] word,
                                                  input logic [1:0]      addr,
                                                  input logic [2:0]      funct3);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{addr, 3'b000} +: 8];
    h = addr[1] ? word[31:16] : word[15:0];
    case (funct3)
      3'b000:  extract_load = {{(XLEN-8){b[7]}}, b};
      3'b001:  extract_load = {{(XLEN-16){h[15]}}, h};
      3'b100:  extract_load = {{(XLEN-8){1'b0}}, b};
      3'b101:  extract_load = {{(XLEN-16){1'b0}}, h};
      default: extract_load = word;
    endcase
  endfunction

  logic [XLEN-1:0] load_m;
  logic [XLEN-1:0] result_m;
  logic            misalign_m;
  logic            we_m;

  assign load_m = extract_load(bus.i_read_data_m, bus.i_alu_result_m[1:0], bus.i_funct3_m);

  always_comb begin
    result_m = bus.i_alu_result_m;
    case (bus.i_result_src_m)
      2'b01:   result_m = load_m;
      2'b10:   result_m = bus.i_pc_plus4_m;
      default: result_m = bus.i_alu_result_m;
    endcase
  end

`ifdef RISCV_LOAD_MISALIGN_EN
  assign misalign_m = bus.i_valid_m && (bus.i_result_src_m == 2'b01) &&
                      (((bus.i_funct3_m[1:0] == 2'b01) && bus.i_alu_result_m[0]) ||
                       ((bus.i_funct3_m == 3'b010) && (bus.i_alu_result_m[1:0] != 2'b00)));
`else
  assign misalign_m = 1'b0;
`endif

  assign we_m = bus.i_reg_write_m && bus.i_valid_m && (bus.i_rd_m != '0) && !misalign_m;

  // ---- M -> W boundary ----
  logic [XLEN-1:0]  result_p0;
  logic [RD_W-1:0]  rd_p0;
  logic             we_p0;
  logic             vld_p0;
  logic             misalign_p0;
  logic [CNT_W-1:0] instret_p0;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      result_p0   <= '0;
      rd_p0       <= '0;
      we_p0       <= 1'b0;
      vld_p0      <= 1'b0;
      misalign_p0 <= 1'b0;
      instret_p0  <= '0;
    end else if (bus.i_flush_w) begin
      result_p0   <= '0;
      rd_p0       <= '0;
      we_p0       <= 1'b0;
      vld_p0      <= 1'b0;
      misalign_p0 <= 1'b0;
    end else if (!bus.i_stall_w) begin
      result_p0   <= result_m;
      rd_p0       <= bus.i_rd_m;
      we_p0       <= we_m;
      vld_p0      <= bus.i_valid_m;
      misalign_p0 <= misalign_m;
      if (bus.i_valid_m) instret_p0 <= instret_p0 + CNT_W'(1);
    end
  end

  assign bus.o_result_w    = result_p0;
  assign bus.o_rd_w        = rd_p0;
  assign bus.o_reg_write_w = we_p0;
  assign bus.o_valid_w     = vld_p0;
  assign bus.o_misalign_w  = misalign_p0;
  assign bus.o_instret     = instret_p0;

endmodule

// File: tb/tb_riscv_mem_wb_stage.sv
// Directed scoreboard bench for riscv_mem_wb_stage; expectations track RISCV_LOAD_MISALIGN_EN.
`timescale 1ns/1ps
module tb_riscv_mem_wb_stage;
  localparam int XLEN = 32;
  localparam int RD_W = 5;
  localparam int CNT_W = 64;

  typedef struct {
    logic [XLEN-1:0]  result;
    logic [RD_W-1:0]  rd;
    logic             we;
    logic             vld;
    logic             mis;
    logic [CNT_W-1:0] cnt;
    string            tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  exp_t last;
  logic [CNT_W-1:0] cnt_model = '0;

  riscv_mem_wb_stage_if #(.XLEN(XLEN), .RD_W(RD_W), .CNT_W(CNT_W)) bus ();

  riscv_mem_wb_stage #(.XLEN(XLEN), .RD_W(RD_W), .CNT_W(CNT_W)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [XLEN-1:0] model_load(logic [XLEN-1:0] w, logic [1:0] a, logic [2:0] f3);
    logic [XLEN-1:0] sh;
    logic [XLEN-1:0] hs;
    sh = w >> (a * 8);
    hs = a[1] ? (w >> 16) : w;
    case (f3)
      3'b000:  return (sh & 32'hFF) | (sh[7] ? 32'hFFFF_FF00 : 32'h0);
      3'b100:  return sh & 32'hFF;
      3'b001:  return (hs & 32'hFFFF) | (hs[15] ? 32'hFFFF_0000 : 32'h0);
      3'b101:  return hs & 32'hFFFF;
      default: return w;
    endcase
  endfunction

  task automatic chk(string tag, logic [CNT_W-1:0] got, logic [CNT_W-1:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, want);
    end
  endtask

  // Computes the expected W state for the inputs currently driven, then clocks and compares.
  task automatic tick(string tag);
    exp_t e;
    exp_t g;
    logic mis;
    e = last;
    e.tag = tag;
    if (rst) begin
      e.result = '0; e.rd = '0; e.we = 0; e.vld = 0; e.mis = 0;
      cnt_model = '0;
    end else if (bus.i_flush_w) begin
      e.result = '0; e.rd = '0; e.we = 0; e.vld = 0; e.mis = 0;
    end else if (!bus.i_stall_w) begin
      mis = 1'b0;
`ifdef RISCV_LOAD_MISALIGN_EN
      if (bus.i_valid_m && bus.i_result_src_m == 2'b01) begin
        if ((bus.i_funct3_m == 3'b001 || bus.i_funct3_m == 3'b101) && bus.i_alu_result_m[0]) mis = 1'b1;
        if (bus.i_funct3_m == 3'b010 && bus.i_alu_result_m[1:0] != 2'b00) mis = 1'b1;
      end
`endif
      if (bus.i_result_src_m == 2'b01)
        e.result = model_load(bus.i_read_data_m, bus.i_alu_result_m[1:0], bus.i_funct3_m);
      else if (bus.i_result_src_m == 2'b10)
        e.result = bus.i_pc_plus4_m;
      else
        e.result = bus.i_alu_result_m;
      e.rd  = bus.i_rd_m;
      e.vld = bus.i_valid_m;
      e.mis = mis;
      e.we  = bus.i_reg_write_m && bus.i_valid_m && (bus.i_rd_m != 0) && !mis;
      if (bus.i_valid_m) cnt_model = cnt_model + 1;
    end
    e.cnt = cnt_model;
    last = e;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $error("FAIL %s: scoreboard empty", tag);
    end else begin
      g = exp_q.pop_front();
      chk({g.tag, ".result"}, CNT_W'(bus.o_result_w), CNT_W'(g.result));
      chk({g.tag, ".rd"}, CNT_W'(bus.o_rd_w), CNT_W'(g.rd));
      chk({g.tag, ".we"}, CNT_W'(bus.o_reg_write_w), CNT_W'(g.we));
      chk({g.tag, ".valid"}, CNT_W'(bus.o_valid_w), CNT_W'(g.vld));
      chk({g.tag, ".misalign"}, CNT_W'(bus.o_misalign_w), CNT_W'(g.mis));
      chk({g.tag, ".instret"}, bus.o_instret, g.cnt);
    end
  endtask

  task automatic drive(logic [1:0] src, logic [2:0] f3, logic [XLEN-1:0] addr,
                       logic [XLEN-1:0] rdata, logic [RD_W-1:0] rd, logic we, logic vld);
    bus.i_result_src_m = src;
    bus.i_funct3_m     = f3;
    bus.i_alu_result_m = addr;
    bus.i_read_data_m  = rdata;
    bus.i_rd_m         = rd;
    bus.i_reg_write_m  = we;
    bus.i_valid_m      = vld;
    bus.i_pc_plus4_m   = 32'h0000_0104;
  endtask

  task automatic rand_inputs();
    drive(2'($urandom), 3'($urandom), $urandom, $urandom, RD_W'($urandom), 1'($urandom), 1'($urandom));
    bus.i_pc_plus4_m = $urandom;
    bus.i_stall_w = 1'($urandom);
    bus.i_flush_w = 1'($urandom);
  endtask

  initial begin
    last = '{result: '0, rd: '0, we: 0, vld: 0, mis: 0, cnt: '0, tag: ""};
    rand_inputs();
    #1;
    rst = 1'b1;
    tick("reset0");
    rand_inputs();
    tick("reset1");

    rst = 1'b0;
    bus.i_stall_w = 0;
    bus.i_flush_w = 0;
    drive(2'b01, 3'b000, 32'h0000_1001, 32'h8000_FF7F, 5'd1, 1, 1); tick("lb_a1");
    drive(2'b01, 3'b100, 32'h0000_1000, 32'h8000_FF7F, 5'd2, 1, 1); tick("lbu_a0");
    drive(2'b01, 3'b001, 32'h0000_1002, 32'h8000_FF7F, 5'd3, 1, 1); tick("lh_a2");
    drive(2'b01, 3'b101, 32'h0000_1000, 32'h8000_FF7F, 5'd4, 1, 1); tick("lhu_a0");
    drive(2'b01, 3'b100, 32'h0000_1003, 32'h8000_FF7F, 5'd6, 1, 1); tick("lbu_a3");
    drive(2'b01, 3'b010, 32'h0000_1000, 32'h8000_FF7F, 5'd7, 1, 1); tick("lw_a0");
    drive(2'b10, 3'b000, 32'h0000_2222, 32'h0, 5'd5, 1, 1);         tick("pc4_rd5");
    drive(2'b10, 3'b000, 32'h0000_2222, 32'h0, 5'd0, 1, 1);         tick("pc4_rd0");
    drive(2'b11, 3'b000, 32'hDEAD_BEEF, 32'h0, 5'd9, 1, 1);         tick("alu_src3");
    drive(2'b00, 3'b000, 32'h1234_5678, 32'h0, 5'd8, 1, 0);         tick("bubble_in");

    drive(2'b00, 3'b000, 32'hCAFE_0001, 32'h0, 5'd10, 1, 1);        tick("pre_stall");
    bus.i_stall_w = 1;
    drive(2'b00, 3'b000, 32'h5555_AAAA, 32'h0, 5'd11, 1, 1);        tick("stall1");
    drive(2'b01, 3'b000, 32'h0000_0001, 32'hFFFF_FFFF, 5'd12, 1, 1); tick("stall2");
    drive(2'b10, 3'b000, 32'h0, 32'h0, 5'd13, 1, 1);                 tick("stall3");
    bus.i_flush_w = 1;
    tick("flush_stall");
    bus.i_flush_w = 0;
    bus.i_stall_w = 0;
    drive(2'b00, 3'b000, 32'h0000_0042, 32'h0, 5'd14, 1, 1);        tick("after_flush");
    bus.i_flush_w = 1;
    tick("flush_only");
    bus.i_flush_w = 0;
    bus.i_stall_w = 1;
    rst = 1;
    tick("reset_in_stall");
    rst = 0;
    bus.i_stall_w = 0;

    #2;
    force dut.instret_p0 = '1;
    #1;
    release dut.instret_p0;
    #1;
    cnt_model = '1;
    chk("instret_preload", bus.o_instret, '1);
    last.cnt = cnt_model;
    drive(2'b00, 3'b000, 32'h0000_0077, 32'h0, 5'd15, 1, 1);        tick("instret_wrap");

    drive(2'b01, 3'b010, 32'h0000_1002, 32'h8000_FF7F, 5'd16, 1, 1); tick("lw_misalign");
    drive(2'b01, 3'b101, 32'h0000_1001, 32'h8000_FF7F, 5'd17, 1, 1); tick("lhu_odd");
    drive(2'b00, 3'b000, 32'h0, 32'h0, 5'd0, 0, 0);                  tick("idle");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
